led_frame_sched: RTL and testbench
==================================

Name: led_frame_sched

Overview:
- Frame-level sequencer for the LED output path, in the fast clock domain.
- Gates the FIFO-writer enable and start strobes, counts the words it writes, and waits for the slow-domain sender to report completion.
- Enforces a minimum inter-frame gap, a transmit watchdog, and continuous or one-shot refresh.
- Reports frame, drop and error status to the CPU.

Parameters:
FRAME_WORDS, 35, FIFO words per frame; must equal the LED_NUM of the sender
MIN_GAP, 1000, clk cycles held in GAP after a frame completes or times out (>=1)
TIMEOUT, 100000, max clk cycles spent in WAIT_TX before watchdog fires (>=1)
CNT_W, 16, width of frame_cnt and drop_cnt

Ports:
clk  in  1  fast clock; the only clock
rstn  in  1  asynchronous active-low reset
arm  in  1  CPU one-cycle pulse: request one frame (one-shot) or start streaming (cont mode)
cont_mode  in  1  1 = re-arm automatically after GAP; sampled on exit from GAP
abort  in  1  synchronous pulse: return to IDLE from any state
stats_valid  in  1  one-cycle pulse from the statistics engine: new Mean data available
we_mon  in  1  FIFO write strobe from the FIFO writer, monitored
tx_done  in  1  one-cycle pulse, already synchronised into clk, meaning the sender finished the frame
err_clr  in  1  pulse: clears timeout_err and proto_err
en_o  out  1  enable to the FIFO writer
start_o  out  1  one-cycle start strobe to the FIFO writer
busy  out  1  high in every state except IDLE
frame_cnt  out  CNT_W  completed frames; wraps
drop_cnt  out  CNT_W  stats_valid pulses not consumed; saturates at all-ones
timeout_err  out  1  sticky; watchdog fired
proto_err  out  1  sticky; we_mon outside LOAD, or we_mon count overflow

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; word counter, gap counter, watchdog counter and arm_pend all 0.
- States: IDLE, ARMED, LOAD, WAIT_TX, GAP.
- IDLE:
  - On arm, or arm_pend set: go to ARMED next cycle and clear arm_pend.
- ARMED:
  - en_o=1.
  - On stats_valid: start_o=1 for exactly one cycle, registered (high the cycle after stats_valid). Clear the word counter and go to LOAD.
- LOAD:
  - en_o=1; each we_mon increments the word counter.
  - When the count reaches FRAME_WORDS, go to WAIT_TX the next cycle, with en_o=0 from that cycle.
  - we_mon in the same cycle as the final count: proto_err=1.
- WAIT_TX:
  - The watchdog counts from 0.
  - tx_done: frame_cnt+1 (wraps), then go to GAP.
  - Watchdog reaches TIMEOUT-1 without tx_done: timeout_err=1, go to GAP, frame_cnt unchanged.
  - tx_done and watchdog expiry in the same cycle: tx_done wins, no error.
- GAP:
  - Load MIN_GAP-1 on entry and count down to 0. At 0, go to ARMED if cont_mode=1, else IDLE.
- arm outside IDLE sets arm_pend. It is ignored in cont_mode, and a second arm while pending is absorbed.
- stats_valid in any state other than ARMED: drop_cnt+1 (saturating). stats_valid in ARMED is consumed and not counted.
- we_mon in any state other than LOAD: proto_err=1; state unaffected.
- abort:
  - Highest priority: next state=IDLE.
  - en_o=0 and start_o=0 next cycle; arm_pend cleared.
  - Counters and sticky flags are held.
  - abort with arm in the same cycle: abort wins, arm dropped.
- err_clr clears the sticky flags. err_clr with a new error in the same cycle: the error wins (flag stays 1).
- No combinational input-to-output paths; all outputs are registered.
- Latency from arm to en_o: 1 cycle.

Decomposition:
- Package led_pkg:
  - State enum sched_state_t (IDLE, ARMED, LOAD, WAIT_TX, GAP), 3-bit encoding.
  - Constant LED_FRAME_WORDS=35, shared with the FIFO writer and sender configuration.
- Sub-module sat_cnt (parameterised width, inc, clr; saturating) for drop_cnt.
- FSM, word, gap and watchdog counters stay in the top body.

Test Plan:
Bench params: MIN_GAP=4, TIMEOUT=20, FRAME_WORDS=35.
1. One-shot frame: arm; stats_valid; 35 we_mon; tx_done 10 cycles later -> en_o high from arm+1 through the 35th write; start_o pulses once; frame_cnt=1; IDLE reached 4 cycles after tx_done; busy=0.
2. Continuous: cont_mode=1; arm; 3 frames with tx_done each -> ARMED re-entered exactly 4 cycles after each tx_done; frame_cnt=3.
3. Watchdog: complete LOAD, withhold tx_done -> timeout_err=1 on the 20th WAIT_TX cycle; frame_cnt unchanged; err_clr -> timeout_err=0.
4. Drops/protocol: 3 stats_valid while in IDLE -> drop_cnt=3; we_mon while in IDLE -> proto_err=1; state unchanged; drop_cnt preset to 0xFFFF plus stats_valid -> stays 0xFFFF.
5. Abort mid-LOAD at word 17 -> IDLE next cycle; en_o=0; next arm plus stats_valid restarts the word count at 0, requiring 35 fresh writes.
6. Simultaneity: tx_done on the same cycle as watchdog expiry -> no timeout_err, frame_cnt+1. arm during WAIT_TX with cont_mode=0 -> ARMED entered after GAP→IDLE. rstn asserted mid-LOAD -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED output path.
package led_pkg;

    // FIFO words per LED frame; the FIFO writer and the sender use the same value.
    localparam int unsigned LED_FRAME_WORDS = 35;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        LOAD    = 3'd2,
        WAIT_TX = 3'd3,
        GAP     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/led_frame_sched.sv
// Frame-level sequencer for the LED output path: gates the FIFO writer,
// counts written words, waits for the sender, and reports status.
module led_frame_sched
    import led_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = LED_FRAME_WORDS,
    parameter int unsigned MIN_GAP     = 1000,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             arm,
    input  logic             cont_mode,
    input  logic             abort,
    input  logic             stats_valid,
    input  logic             we_mon,
    input  logic             tx_done,
    input  logic             err_clr,
    output logic             en_o,
    output logic             start_o,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             timeout_err,
    output logic             proto_err
);

    localparam int unsigned WORD_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [WORD_W-1:0] word_cnt;
    logic [WORD_W-1:0] word_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_cnt_nxt;
    logic              arm_pend;
    logic              arm_pend_nxt;
    logic              en_nxt;
    logic              start_nxt;
    logic              busy_nxt;
    logic [CNT_W-1:0]  frame_cnt_nxt;
    logic              timeout_err_nxt;
    logic              proto_err_nxt;
    logic              drop_inc;
    logic              frame_full;
    logic              wd_expired;

    assign frame_full = (word_cnt == WORD_W'(FRAME_WORDS));
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides everything.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (arm || arm_pend) state_nxt = ARMED;
                ARMED:   if (stats_valid) state_nxt = LOAD;
                LOAD:    if (frame_full) state_nxt = WAIT_TX;
                WAIT_TX: if (tx_done || wd_expired) state_nxt = GAP;
                GAP:     if (gap_cnt == '0) state_nxt = cont_mode ? ARMED : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs, counters and pending-arm flag.
    always_comb begin
        en_nxt          = (state_nxt == ARMED) || (state_nxt == LOAD);
        start_nxt       = !abort && (state == ARMED) && stats_valid;
        busy_nxt        = (state_nxt != IDLE);
        word_cnt_nxt    = word_cnt;
        gap_cnt_nxt     = gap_cnt;
        wd_cnt_nxt      = '0;
        arm_pend_nxt    = arm_pend;
        frame_cnt_nxt   = frame_cnt;
        drop_inc        = stats_valid && (state != ARMED);
        timeout_err_nxt = timeout_err && !err_clr;
        proto_err_nxt   = proto_err && !err_clr;

        if ((state == ARMED) && stats_valid) begin
            word_cnt_nxt = '0;
        end else if ((state == LOAD) && we_mon && !frame_full) begin
            word_cnt_nxt = word_cnt + WORD_W'(1);
        end

        if ((state_nxt == GAP) && (state != GAP)) begin
            gap_cnt_nxt = GAP_W'(MIN_GAP - 1);
        end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end

        if ((state == WAIT_TX) && (state_nxt == WAIT_TX)) begin
            wd_cnt_nxt = wd_cnt + WD_W'(1);
        end

        // A pending arm is consumed by IDLE; cont mode re-arms on its own.
        if (abort || (state == IDLE)) begin
            arm_pend_nxt = 1'b0;
        end else if (arm && !cont_mode) begin
            arm_pend_nxt = 1'b1;
        end

        if (!abort && (state == WAIT_TX)) begin
            if (tx_done) begin
                frame_cnt_nxt = frame_cnt + CNT_W'(1);
            end else if (wd_expired) begin
                timeout_err_nxt = 1'b1;
            end
        end

        if (we_mon && ((state != LOAD) || frame_full)) begin
            proto_err_nxt = 1'b1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_o        <= 1'b0;
            start_o     <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            arm_pend    <= 1'b0;
        end else begin
            en_o        <= en_nxt;
            start_o     <= start_nxt;
            busy        <= busy_nxt;
            frame_cnt   <= frame_cnt_nxt;
            timeout_err <= timeout_err_nxt;
            proto_err   <= proto_err_nxt;
            word_cnt    <= word_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            wd_cnt      <= wd_cnt_nxt;
            arm_pend    <= arm_pend_nxt;
        end
    end

    // Dropped statistics updates, saturating.
    sat_cnt #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (drop_inc),
        .clr  (1'b0),
        .cnt  (drop_cnt)
    );

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: cycle model plus directed scenarios.
module tb_led_frame_sched;

    localparam int unsigned FW   = 35;
    localparam int unsigned MG   = 4;
    localparam int unsigned TO   = 20;
    localparam int unsigned CW   = 16;
    localparam int          CMAX = 65535;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_LOAD  = 2;
    localparam int M_WAIT  = 3;
    localparam int M_GAP   = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          arm = 1'b0;
    logic          cont_mode = 1'b0;
    logic          abort = 1'b0;
    logic          stats_valid = 1'b0;
    logic          we_mon = 1'b0;
    logic          tx_done = 1'b0;
    logic          err_clr = 1'b0;
    logic          en_o;
    logic          start_o;
    logic          busy;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;
    logic          timeout_err;
    logic          proto_err;

    int n_checks = 0;
    int n_fail = 0;
    int start_pulses = 0;

    // Model: phase, words written, WAIT cycles elapsed, GAP cycles remaining.
    int m_mode = M_IDLE;
    int m_words = 0;
    int m_waited = 0;
    int m_gap_left = 0;
    int m_frames = 0;
    int m_drops = 0;
    bit m_pend = 0;
    bit m_terr = 0;
    bit m_perr = 0;
    bit m_en = 0;
    bit m_start = 0;
    bit m_busy = 0;

    led_frame_sched #(
        .FRAME_WORDS (FW),
        .MIN_GAP     (MG),
        .TIMEOUT     (TO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .arm         (arm),
        .cont_mode   (cont_mode),
        .abort       (abort),
        .stats_valid (stats_valid),
        .we_mon      (we_mon),
        .tx_done     (tx_done),
        .err_clr     (err_clr),
        .en_o        (en_o),
        .start_o     (start_o),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt),
        .timeout_err (timeout_err),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int nmode;
        bit st;
        bit tset;
        bit pset;
        nmode = m_mode;
        st    = 1'b0;
        tset  = 1'b0;
        pset  = we_mon && !((m_mode == M_LOAD) && (m_words < int'(FW)));
        if (stats_valid && (m_mode != M_ARMED) && (m_drops < CMAX)) m_drops++;
        if (abort) begin
            nmode  = M_IDLE;
            m_pend = 1'b0;
        end else begin
            if ((m_mode != M_IDLE) && arm && !cont_mode) m_pend = 1'b1;
            case (m_mode)
                M_IDLE: begin
                    if (arm || m_pend) begin
                        nmode  = M_ARMED;
                        m_pend = 1'b0;
                    end
                end
                M_ARMED: begin
                    if (stats_valid) begin
                        nmode   = M_LOAD;
                        st      = 1'b1;
                        m_words = 0;
                    end
                end
                M_LOAD: begin
                    if (m_words == int'(FW)) begin
                        nmode    = M_WAIT;
                        m_waited = 0;
                    end else if (we_mon) begin
                        m_words++;
                    end
                end
                M_WAIT: begin
                    m_waited++;
                    if (tx_done) begin
                        m_frames   = (m_frames + 1) % 65536;
                        nmode      = M_GAP;
                        m_gap_left = int'(MG);
                    end else if (m_waited == int'(TO)) begin
                        tset       = 1'b1;
                        nmode      = M_GAP;
                        m_gap_left = int'(MG);
                    end
                end
                M_GAP: begin
                    m_gap_left--;
                    if (m_gap_left == 0) nmode = cont_mode ? M_ARMED : M_IDLE;
                end
                default: nmode = M_IDLE;
            endcase
        end
        m_terr  = tset || (m_terr && !err_clr);
        m_perr  = pset || (m_perr && !err_clr);
        m_en    = (nmode == M_ARMED) || (nmode == M_LOAD);
        m_start = st;
        m_busy  = (nmode != M_IDLE);
        m_mode  = nmode;
    endtask

    // Advance the model on each clock, reset it with the DUT.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode = M_IDLE; m_words = 0; m_waited = 0; m_gap_left = 0;
            m_frames = 0; m_drops = 0; m_pend = 0; m_terr = 0; m_perr = 0;
            m_en = 0; m_start = 0; m_busy = 0;
        end else begin
            model_step();
        end
    end

    // Compare every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            chk("m_en_o", 32'(en_o), 32'(m_en));
            chk("m_start_o", 32'(start_o), 32'(m_start));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_frame_cnt", 32'(frame_cnt), 32'(m_frames));
            chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
            chk("m_timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("m_proto_err", 32'(proto_err), 32'(m_perr));
            if (start_o === 1'b1) start_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            we_mon = 1'b1;
            step();
        end
        we_mon = 1'b0;
    endtask

    // arm, stats_valid, full frame of writes; ends at the start of WAIT_TX cycle 1.
    task automatic run_to_wait();
        arm = 1'b1;
        step();
        arm = 1'b0;
        stats_valid = 1'b1;
        step();
        stats_valid = 1'b0;
        load_words(int'(FW));
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " en_o"}, 32'(en_o), 32'd0);
        chk({tag, " start_o"}, 32'(start_o), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, " proto_err"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        repeat (3) step();
        chk_all_zero("reset");
        rstn = 1'b1;
        step();

        // One-shot frame.
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("t1 en after arm", 32'(en_o), 32'd1);
        chk("t1 busy after arm", 32'(busy), 32'd1);
        stats_valid = 1'b1;
        step();
        stats_valid = 1'b0;
        chk("t1 start pulse", 32'(start_o), 32'd1);
        load_words(int'(FW));
        chk("t1 en at final count", 32'(en_o), 32'd1);
        step();
        chk("t1 en off in wait", 32'(en_o), 32'd0);
        repeat (9) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t1 frame_cnt", 32'(frame_cnt), 32'd1);
        repeat (3) step();
        chk("t1 busy in gap", 32'(busy), 32'd1);
        step();
        chk("t1 idle after gap", 32'(busy), 32'd0);
        chk("t1 start pulses", 32'(start_pulses), 32'd1);

        // Continuous refresh, three frames.
        cont_mode = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int f = 0; f < 3; f++) begin
            stats_valid = 1'b1;
            step();
            stats_valid = 1'b0;
            load_words(int'(FW));
            step();
            repeat (2) step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            repeat (3) step();
            chk("t2 still in gap", 32'(en_o), 32'd0);
            step();
            chk("t2 re-armed", 32'(en_o), 32'd1);
        end
        chk("t2 frame_cnt", 32'(frame_cnt), 32'd4);
        cont_mode = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t2 abort idle", 32'(busy), 32'd0);
        chk("t2 abort en", 32'(en_o), 32'd0);

        // Watchdog.
        run_to_wait();
        repeat (19) step();
        chk("t3 no timeout yet", 32'(timeout_err), 32'd0);
        step();
        chk("t3 timeout", 32'(timeout_err), 32'd1);
        chk("t3 frame_cnt held", 32'(frame_cnt), 32'd4);
        repeat (4) step();
        chk("t3 idle", 32'(busy), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3 err_clr", 32'(timeout_err), 32'd0);

        // Drops and protocol errors.
        stats_valid = 1'b1;
        repeat (3) step();
        stats_valid = 1'b0;
        chk("t4 drop_cnt", 32'(drop_cnt), 32'd3);
        we_mon = 1'b1;
        step();
        we_mon = 1'b0;
        chk("t4 proto_err", 32'(proto_err), 32'd1);
        chk("t4 state kept", 32'(busy), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4 proto clr", 32'(proto_err), 32'd0);
        stats_valid = 1'b1;
        repeat (65532) step();
        chk("t4 drop max", 32'(drop_cnt), 32'h0000_FFFF);
        repeat (2) step();
        stats_valid = 1'b0;
        chk("t4 drop sat", 32'(drop_cnt), 32'h0000_FFFF);

        // Abort mid-LOAD, then a fresh full frame.
        arm = 1'b1;
        step();
        arm = 1'b0;
        stats_valid = 1'b1;
        step();
        stats_valid = 1'b0;
        load_words(17);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5 abort idle", 32'(busy), 32'd0);
        chk("t5 abort en", 32'(en_o), 32'd0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        stats_valid = 1'b1;
        step();
        stats_valid = 1'b0;
        load_words(34);
        step();
        chk("t5 34 words still load", 32'(en_o), 32'd1);
        we_mon = 1'b1;
        step();
        we_mon = 1'b0;
        chk("t5 final count en", 32'(en_o), 32'd1);
        step();
        chk("t5 wait after 35", 32'(en_o), 32'd0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t5 frame_cnt", 32'(frame_cnt), 32'd5);
        chk("t5 no proto", 32'(proto_err), 32'd0);
        repeat (4) step();

        // tx_done on the watchdog expiry cycle.
        run_to_wait();
        repeat (19) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t6 tx wins timeout", 32'(timeout_err), 32'd0);
        chk("t6 frame_cnt", 32'(frame_cnt), 32'd6);
        repeat (4) step();

        // arm during WAIT_TX is held until after GAP -> IDLE.
        run_to_wait();
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (4) step();
        chk("t6 idle after gap", 32'(busy), 32'd0);
        step();
        chk("t6 pend armed en", 32'(en_o), 32'd1);
        chk("t6 pend armed busy", 32'(busy), 32'd1);
        chk("t6 frame_cnt", 32'(frame_cnt), 32'd7);

        // Asynchronous reset mid-LOAD.
        stats_valid = 1'b1;
        step();
        stats_valid = 1'b0;
        load_words(5);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("t6 async reset");
        step();
        rstn = 1'b1;
        step();
        chk("t6 idle after reset", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
